// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared bus widths, master IDs and FSM encoding for the RAM arbiter.
package ram_arbiter_pkg;
    localparam int MemAddrBus = 32;
    localparam int MemBus = 32;
    localparam int NUM_MASTERS = 3;
    localparam logic [1:0] M_LSU = 2'd0;
    localparam logic [1:0] M_JTAG = 2'd1;
    localparam logic [1:0] M_UART = 2'd2;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner select; round-robin after ptr, or fixed
// priority 1 > 2 > 0 when RAM_ARB_FIXED_PRIO_EN is defined.
module ram_arb_pick
    import ram_arbiter_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [1:0]             ptr,
    output logic [1:0]             id,
    output logic                   valid
);
    assign valid = |req;
`ifdef RAM_ARB_FIXED_PRIO_EN
    assign id = req[M_JTAG] ? M_JTAG : req[M_UART] ? M_UART : M_LSU;
`else
    logic [1:0] c;
    // Walk the order backwards so the earliest requester after ptr wins.
    always_comb begin
        id = M_LSU;
        c = ptr;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            c = 2'((int'(ptr) + k) % NUM_MASTERS);
            id = req[c] ? c : id;
        end
    end
`endif
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between core LSU, JTAG and UART loader.
// RAM_ARB_FIXED_PRIO_EN switches arbitration to fixed priority 1 > 2 > 0.
module ram_arbiter
    import ram_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             req_i,
    input  logic [2:0]             lock_i,
    input  logic [2:0]             we_i,
    input  logic [MemAddrBus-1:0]  addr0_i,
    input  logic [MemAddrBus-1:0]  addr1_i,
    input  logic [MemAddrBus-1:0]  addr2_i,
    input  logic [MemBus-1:0]      data0_i,
    input  logic [MemBus-1:0]      data1_i,
    input  logic [MemBus-1:0]      data2_i,
    output logic [MemBus-1:0]      rdata_o,
    output logic [2:0]             ack_o,
    output logic                   ram_we_o,
    output logic [MemAddrBus-1:0]  ram_addr_o,
    output logic [MemBus-1:0]      ram_data_o,
    input  logic [MemBus-1:0]      ram_data_i,
    output logic                   hold_core_o
);
    state_t state, state_nx;
    logic [1:0] gnt_id, gnt_nx, rr_ptr, rr_nx, pick_id;
    logic [2:0] gnt_oh, pick_req;
    logic busy, live, pick_vld;

    assign busy = state == BUSY;
    assign gnt_oh = 3'b001 << gnt_id;
    // A beat completes only while the owner still requests; reset aborts it.
    assign live = busy && req_i[gnt_id] && !rst;
`ifdef RAM_ARB_FIXED_PRIO_EN
    assign pick_req = req_i;
`else
    assign pick_req = busy ? req_i & ~gnt_oh : req_i;
`endif

    ram_arb_pick u_pick (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .id    (pick_id),
        .valid (pick_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt_id <= M_LSU;
            rr_ptr <= M_UART;
        end else begin
            state <= state_nx;
            gnt_id <= gnt_nx;
            rr_ptr <= rr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        gnt_nx = gnt_id;
        rr_nx = rr_ptr;
        if (!busy || (live && !lock_i[gnt_id])) begin
            state_nx = pick_vld ? BUSY : IDLE;
            gnt_nx = pick_vld ? pick_id : gnt_id;
            rr_nx = pick_vld ? pick_id : rr_ptr;
        end else if (!live) begin
            state_nx = IDLE;
        end
    end

    always_comb begin
        ram_addr_o = '0;
        ram_data_o = '0;
        if (busy) begin
            ram_addr_o = gnt_id == M_JTAG ? addr1_i : gnt_id == M_UART ? addr2_i : addr0_i;
            ram_data_o = gnt_id == M_JTAG ? data1_i : gnt_id == M_UART ? data2_i : data0_i;
        end
    end

    assign ram_we_o = live && we_i[gnt_id];
    assign ack_o = live ? gnt_oh : 3'b000;
    assign rdata_o = live ? ram_data_i : '0;
    assign hold_core_o = req_i[M_LSU] && !(busy && gnt_id == M_LSU);
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model of ownership and RAM contents.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] req, lock, we, ack_o;
    logic [31:0] addr [3];
    logic [31:0] data [3];
    logic [31:0] rdata_o, ram_addr_o, ram_data_o, ram_data_i;
    logic ram_we_o, hold_core_o;
    int errs = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .lock_i      (lock),
        .we_i        (we),
        .addr0_i     (addr[0]),
        .addr1_i     (addr[1]),
        .addr2_i     (addr[2]),
        .data0_i     (data[0]),
        .data1_i     (data[1]),
        .data2_i     (data[2]),
        .rdata_o     (rdata_o),
        .ack_o       (ack_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_data_o  (ram_data_o),
        .ram_data_i  (ram_data_i),
        .hold_core_o (hold_core_o)
    );

    function automatic logic [31:0] seed(int i);
        return i == 4 ? 32'hDEADBEEF : 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
    endfunction

    // RAM attached to the DUT, combinational read, synchronous write.
    logic [31:0] ram [256];
    bit ram_init = 1'b0;
    assign ram_data_i = ram[ram_addr_o[9:2]];
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= seed(i);
            ram_init <= 1'b1;
        end else if (ram_we_o) begin
            ram[ram_addr_o[9:2]] <= ram_data_o;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Model: who owns the RAM this cycle, the rotation pointer, expected memory.
    bit m_busy;
    int m_gnt, m_ptr;
    logic [31:0] ref_mem [256];
    bit ref_init = 1'b0;

    always @(posedge clk) begin : mdl
        logic own;
        int w, c;
        logic [31:0] a;
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
            ref_init = 1'b1;
        end
        if (rst) begin
            m_busy = 1'b0;
            m_gnt = 0;
            m_ptr = 2;
        end else begin
            own = m_busy && req[m_gnt];
            if (own && we[m_gnt]) begin
                a = addr[m_gnt];
                ref_mem[a[9:2]] = data[m_gnt];
            end
            if (!m_busy || (own && !lock[m_gnt])) begin
                w = -1;
                for (int k = 1; k <= 3; k++) begin
                    c = (m_ptr + k) % 3;
                    if (w < 0 && req[c] && !(m_busy && c == m_gnt)) w = c;
                end
                if (w >= 0) begin
                    m_busy = 1'b1;
                    m_gnt = w;
                    m_ptr = w;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (!own) begin
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic own;
        logic [31:0] a, m;
        if (chk_en) begin
            own = m_busy && req[m_gnt] && !rst;
            a = m_busy ? addr[m_gnt] : 32'h0;
            m = ref_mem[a[9:2]];
            chk("ack", ack_o, own ? 32'(1) << m_gnt : 32'h0);
            chk("ram_we", ram_we_o, own && we[m_gnt]);
            chk("ram_addr", ram_addr_o, a);
            chk("ram_data", ram_data_o, m_busy ? data[m_gnt] : 32'h0);
            chk("rdata", rdata_o, own ? m : 32'h0);
            chk("hold_core", hold_core_o, req[0] && !(m_busy && m_gnt == 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r8;
        rst = 1'b1;
        req = '0;
        lock = '0;
        we = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0;
            data[i] = '0;
        end
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // Single LSU read of RAM[4].
        req = 3'b001;
        addr[0] = 32'h10;
        @(negedge clk);
        chk("rd_idle_ack", ack_o, 32'h0);
        chk("rd_idle_hold", hold_core_o, 32'h1);
        tick();
        @(negedge clk);
        chk("rd_ack", ack_o, 32'h1);
        chk("rd_data", rdata_o, 32'hDEADBEEF);
        chk("rd_hold", hold_core_o, 32'h0);
        tick();
        req = '0;
        @(negedge clk);
        chk("rd_after_hold", hold_core_o, 32'h0);
        tick();

        // Round-robin rotation from reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 3'b111;
        for (int i = 0; i < 3; i++) addr[i] = 32'(i) << 2;
        @(negedge clk);
        chk("rr_idle_ack", ack_o, 32'h0);
        tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rr_ack%0d", i), ack_o, 32'(1) << (i % 3));
            tick();
        end
        req = '0;
        tick();

        // Locked UART burst while the core waits.
        req = 3'b100;
        lock = 3'b100;
        we = 3'b100;
        addr[2] = 32'h100;
        data[2] = 32'h1;
        @(negedge clk);
        chk("burst_idle_hold", hold_core_o, 32'h0);
        tick();
        req = 3'b101;
        addr[0] = 32'h40;
        for (int k = 0; k < 4; k++) begin
            addr[2] = 32'h100 + 32'(4 * k);
            data[2] = 32'(k + 1);
            lock = k < 3 ? 3'b100 : 3'b000;
            @(negedge clk);
            chk($sformatf("burst_ack%0d", k), ack_o, 32'h4);
            chk($sformatf("burst_hold%0d", k), hold_core_o, 32'h1);
            tick();
        end
        req = 3'b001;
        we = '0;
        lock = '0;
        @(negedge clk);
        chk("burst_then_lsu", ack_o, 32'h1);
        for (int k = 0; k < 4; k++) chk($sformatf("burst_ram%0d", k), ram[64 + k], 32'(k + 1));
        tick();
        req = '0;
        tick();

        // Reset in the middle of a JTAG write.
        r8 = ram[8];
        req = 3'b010;
        lock = 3'b010;
        we = 3'b010;
        addr[1] = 32'h20;
        data[1] = 32'hAAAA5555;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_we", ram_we_o, 32'h0);
        tick();
        rst = 1'b0;
        req = '0;
        lock = '0;
        we = '0;
        @(negedge clk);
        chk("rst_ram8", ram[8], r8);
        chk("rst_ack", ack_o, 32'h0);
        chk("rst_addr", ram_addr_o, 32'h0);
        chk("rst_data", ram_data_o, 32'h0);
        tick();

        // JTAG drops its request while granted.
        req = 3'b010;
        lock = 3'b010;
        we = 3'b010;
        addr[1] = 32'h24;
        data[1] = 32'h12345678;
        tick();
        @(negedge clk);
        chk("drop_beat_we", ram_we_o, 32'h1);
        tick();
        req = 3'b000;
        @(negedge clk);
        chk("drop_we", ram_we_o, 32'h0);
        chk("drop_ack", ack_o, 32'h0);
        tick();
        req = 3'b010;
        @(negedge clk);
        chk("drop_idle_ack", ack_o, 32'h0);
        tick();
        req = '0;
        lock = '0;
        we = '0;
        tick();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst = $urandom_range(0, 63) == 0;
            for (int i = 0; i < 3; i++) begin
                addr[i] = 32'($urandom_range(0, 255)) << 2;
                data[i] = $urandom;
            end
            req = 3'($urandom) | 3'($urandom);
            lock = 3'($urandom);
            we = 3'($urandom);
            tick();
        end
        rst = 1'b0;
        req = '0;
        tick();
        for (int i = 0; i < 256; i++) chk($sformatf("ram_word%0d", i), ram[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
